// File: rtl/multicyc_mcu.sv
// rtl/multicyc_mcu.sv - multicycle MIPS main control sequencer with mem_ready wait, timeout and illegal-opcode trap
module multicyc_mcu #(
  parameter int MAX_WAIT       = 16,
  parameter bit IGNORE_ILLEGAL = 1'b0,
  parameter bit EN_ADDIU       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src_sel,
  output logic       iord_sel,
  output logic       ir_we,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       reg_we,
  output logic       wreg_dst_sel,
  output logic       wrbck_data_sel,
  output logic       alu_srca_sel,
  output logic [1:0] alu_srcb_sel,
  output logic       is_beq,
  output logic [3:0] aluop,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                         S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH = 4'd8,
                         S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
                         S_TRAP   = 4'd12;

  // ALU operation codes shared with the datapath; ADD is the all-zero idle code.
  localparam logic [3:0] ALUOP_ADD  = 4'd0, ALUOP_ADDU = 4'd1,
                         ALUOP_SUB  = 4'd2, ALUOP_RR   = 4'd15;

  localparam logic [5:0] OP_RR = 6'b000000, OP_LW   = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J   = 6'b000010,
                         OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;

  localparam logic [31:0] WAIT_LAST = (MAX_WAIT > 0) ? 32'(MAX_WAIT - 1) : 32'd0;

  logic [3:0]  state, next_state;
  logic [31:0] wait_cnt;
  logic        illegal_q, bus_err_q;
  logic        set_illegal, set_bus_err;
  logic        mem_wait, timeout;

  // Memory-facing states stall while mem_ready is low; the last allowed stall cycle times out.
  assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;
  assign timeout  = (MAX_WAIT > 0) && mem_wait && (wait_cnt == WAIT_LAST);

  // State register, wait counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      wait_cnt  <= 32'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) wait_cnt <= 32'd0;
      else if (mem_wait)       wait_cnt <= wait_cnt + 32'd1;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  // Next-state decode, including opcode dispatch and the wait-state timeout.
  always_comb begin
    next_state  = state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) begin next_state = S_TRAP; set_bus_err = 1'b1; end
      end
      S_DECODE: begin
        case (opcode)
          OP_RR:         next_state = S_EXEC;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          OP_ADDI:       next_state = S_ADDIEX;
          OP_ADDIU: begin
            if (EN_ADDIU)            next_state = S_ADDIEX;
            else if (IGNORE_ILLEGAL) next_state = S_FETCH;
            else begin next_state = S_TRAP; set_illegal = 1'b1; end
          end
          default: begin
            if (IGNORE_ILLEGAL) next_state = S_FETCH;
            else begin next_state = S_TRAP; set_illegal = 1'b1; end
          end
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    next_state = S_MEMWB;
        else if (timeout) begin next_state = S_TRAP; set_bus_err = 1'b1; end
      end
      S_MEMWR: begin
        if (mem_ready)    next_state = S_FETCH;
        else if (timeout) begin next_state = S_TRAP; set_bus_err = 1'b1; end
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state = S_FETCH;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_FETCH;
    endcase
  end

  // Moore control word per state; reset forces every control output low at once.
  always_comb begin
    pc_we = 1'b0; pc_src_sel = 2'b00; iord_sel = 1'b0; ir_we = 1'b0;
    mem_rd = 1'b0; mem_we = 1'b0; reg_we = 1'b0; wreg_dst_sel = 1'b0;
    wrbck_data_sel = 1'b0; alu_srca_sel = 1'b0; alu_srcb_sel = 2'b00;
    is_beq = 1'b0; aluop = ALUOP_ADD;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_rd = 1'b1; alu_srcb_sel = 2'b01;
          ir_we = mem_ready; pc_we = mem_ready;
        end
        S_DECODE: alu_srcb_sel = 2'b11;
        S_MEMADR: begin alu_srca_sel = 1'b1; alu_srcb_sel = 2'b10; end
        S_MEMRD:  begin iord_sel = 1'b1; mem_rd = 1'b1; end
        S_MEMWB:  begin reg_we = 1'b1; wrbck_data_sel = 1'b1; end
        S_MEMWR:  begin iord_sel = 1'b1; mem_we = 1'b1; end
        S_EXEC:   begin alu_srca_sel = 1'b1; aluop = ALUOP_RR; end
        S_ALUWB:  begin reg_we = 1'b1; wreg_dst_sel = 1'b1; end
        S_BRANCH: begin
          alu_srca_sel = 1'b1; aluop = ALUOP_SUB; is_beq = 1'b1; pc_src_sel = 2'b01;
        end
        S_ADDIEX: begin
          alu_srca_sel = 1'b1; alu_srcb_sel = 2'b10;
          aluop = (EN_ADDIU && opcode == OP_ADDIU) ? ALUOP_ADDU : ALUOP_ADD;
        end
        S_ADDIWB: reg_we = 1'b1;
        S_JUMP:   begin pc_we = 1'b1; pc_src_sel = 2'b10; end
        default: ;
      endcase
    end
  end

  assign illegal_op = rst_n & illegal_q;
  assign bus_err    = rst_n & bus_err_q;
  assign state_o    = state;

endmodule

// File: tb/tb_multicyc_mcu.sv
// tb/tb_multicyc_mcu.sv - scoreboard bench for multicyc_mcu in two parameter configurations
module tb_multicyc_mcu;

  localparam logic [3:0] A_ADD = 4'd0, A_ADDU = 4'd1, A_SUB = 4'd2, A_RR = 4'd15;
  localparam logic [5:0] O_RR = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000,
                         O_ADDIU = 6'b001001, O_BAD = 6'b111111;

  logic clk, rst_n, mem_ready;
  logic [5:0] opcode;

  logic pc_we_a, iord_a, ir_we_a, mem_rd_a, mem_we_a, reg_we_a, wdst_a, wb_a, srca_a, beq_a, ill_a, berr_a;
  logic [1:0] pcs_a, srcb_a;
  logic [3:0] aluop_a, st_a;
  logic pc_we_b, iord_b, ir_we_b, mem_rd_b, mem_we_b, reg_we_b, wdst_b, wb_b, srca_b, beq_b, ill_b, berr_b;
  logic [1:0] pcs_b, srcb_b;
  logic [3:0] aluop_b, st_b;
  logic [17:0] ctrl_a, ctrl_b;

  assign ctrl_a = {pc_we_a, pcs_a, iord_a, ir_we_a, mem_rd_a, mem_we_a, reg_we_a, wdst_a, wb_a, srca_a, srcb_a, beq_a, aluop_a};
  assign ctrl_b = {pc_we_b, pcs_b, iord_b, ir_we_b, mem_rd_b, mem_we_b, reg_we_b, wdst_b, wb_b, srca_b, srcb_b, beq_b, aluop_b};

  multicyc_mcu #(.MAX_WAIT(4), .IGNORE_ILLEGAL(1'b0), .EN_ADDIU(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_we(pc_we_a), .pc_src_sel(pcs_a), .iord_sel(iord_a), .ir_we(ir_we_a),
    .mem_rd(mem_rd_a), .mem_we(mem_we_a), .reg_we(reg_we_a), .wreg_dst_sel(wdst_a),
    .wrbck_data_sel(wb_a), .alu_srca_sel(srca_a), .alu_srcb_sel(srcb_a), .is_beq(beq_a),
    .aluop(aluop_a), .illegal_op(ill_a), .bus_err(berr_a), .state_o(st_a));

  multicyc_mcu #(.MAX_WAIT(0), .IGNORE_ILLEGAL(1'b1), .EN_ADDIU(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_we(pc_we_b), .pc_src_sel(pcs_b), .iord_sel(iord_b), .ir_we(ir_we_b),
    .mem_rd(mem_rd_b), .mem_we(mem_we_b), .reg_we(reg_we_b), .wreg_dst_sel(wdst_b),
    .wrbck_data_sel(wb_b), .alu_srca_sel(srca_b), .alu_srcb_sel(srcb_b), .is_beq(beq_b),
    .aluop(aluop_b), .illegal_op(ill_b), .bus_err(berr_b), .state_o(st_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] st; logic rdy; } ent_t;
  ent_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference control word for a state, independent of the DUT.
  function automatic logic [17:0] model(input logic [3:0] s, input logic [5:0] op, input logic rdy);
    logic pw = 0, io = 0, iw = 0, mr = 0, mw = 0, rw = 0, wd = 0, wb = 0, sa = 0, bq = 0;
    logic [1:0] ps = 0, sbs = 0;
    logic [3:0] ao = A_ADD;
    case (s)
      4'd0:  begin mr = 1; sbs = 2'b01; iw = rdy; pw = rdy; end
      4'd1:  sbs = 2'b11;
      4'd2:  begin sa = 1; sbs = 2'b10; end
      4'd3:  begin io = 1; mr = 1; end
      4'd4:  begin rw = 1; wb = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin sa = 1; ao = A_RR; end
      4'd7:  begin rw = 1; wd = 1; end
      4'd8:  begin sa = 1; ao = A_SUB; bq = 1; ps = 2'b01; end
      4'd9:  begin sa = 1; sbs = 2'b10; ao = (op == O_ADDIU) ? A_ADDU : A_ADD; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, ps, io, iw, mr, mw, rw, wd, wb, sa, sbs, bq, ao};
  endfunction

  task automatic push(input logic [3:0] s, input logic r);
    ent_t e;
    e.st = s; e.rdy = r;
    sb.push_back(e);
  endtask

  // Expected state trace of one instruction with fw fetch stalls and mw data stalls.
  task automatic issue(input logic [5:0] op, input int fw, input int mw, input logic sel);
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'b0);
    case (op)
      O_RR:   begin push(4'd6, 1'b0); push(4'd7, 1'b0); end
      O_LW:   begin push(4'd2, 1'b0); for (int i = 0; i < mw; i++) push(4'd3, 1'b0);
                    push(4'd3, 1'b1); push(4'd4, 1'b0); end
      O_SW:   begin push(4'd2, 1'b0); for (int i = 0; i < mw; i++) push(4'd5, 1'b0);
                    push(4'd5, 1'b1); end
      O_BEQ:  push(4'd8, 1'b0);
      O_J:    push(4'd11, 1'b0);
      O_ADDI: begin push(4'd9, 1'b0); push(4'd10, 1'b0); end
      O_ADDIU: if (!sel) begin push(4'd9, 1'b0); push(4'd10, 1'b0); end
      default: if (!sel) push(4'd12, 1'b0);
    endcase
  endtask

  // Replay the scoreboard one cycle per entry, starting and ending on a falling edge.
  task automatic drain(input logic [5:0] op, input logic sel);
    ent_t e;
    opcode = op;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      #1;
      chk($sformatf("state op%h", op), {28'd0, sel ? st_b : st_a}, {28'd0, e.st});
      chk($sformatf("ctrl op%h s%0d", op, e.st), {14'd0, sel ? ctrl_b : ctrl_a},
          {14'd0, model(e.st, op, e.rdy)});
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst state_a", {28'd0, st_a}, 32'd0);
    chk("rst state_b", {28'd0, st_b}, 32'd0);
    chk("rst ctrl_a", {14'd0, ctrl_a}, 32'd0);
    chk("rst flags_a", {30'd0, ill_a, berr_a}, 32'd0);
    chk("rst flags_b", {30'd0, ill_b, berr_b}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    do_reset();

    // Configuration A: normal decode, stalls up to the timeout boundary.
    issue(O_RR, 3, 0, 1'b0);    drain(O_RR, 1'b0);
    issue(O_LW, 0, 3, 1'b0);    drain(O_LW, 1'b0);
    issue(O_SW, 0, 1, 1'b0);    drain(O_SW, 1'b0);
    issue(O_BEQ, 0, 0, 1'b0);   drain(O_BEQ, 1'b0);
    issue(O_J, 0, 0, 1'b0);     drain(O_J, 1'b0);
    issue(O_ADDI, 0, 0, 1'b0);  drain(O_ADDI, 1'b0);
    issue(O_ADDIU, 0, 0, 1'b0); drain(O_ADDIU, 1'b0);
    issue(O_LW, 2, 3, 1'b0);    drain(O_LW, 1'b0);
    chk("flags_a clean", {30'd0, ill_a, berr_a}, 32'd0);

    // Reset while a store is waiting in MEMWR.
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd2, 1'b0);
    drain(O_SW, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("midrst pre state", {28'd0, st_a}, 32'd5);
    chk("midrst pre mem_we", {31'd0, mem_we_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst ctrl now", {14'd0, ctrl_a}, 32'd0);
    do_reset();

    // Store stuck waiting: four stall cycles then bus error trap.
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd2, 1'b0);
    for (int i = 0; i < 4; i++) push(4'd5, 1'b0);
    push(4'd12, 1'b0); push(4'd12, 1'b1);
    drain(O_SW, 1'b0);
    chk("timeout bus_err", {31'd0, berr_a}, 32'd1);
    chk("timeout illegal", {31'd0, ill_a}, 32'd0);
    do_reset();

    // Unknown opcode traps and stays trapped.
    issue(O_BAD, 0, 0, 1'b0);
    push(4'd12, 1'b1); push(4'd12, 1'b1);
    drain(O_BAD, 1'b0);
    chk("illegal sticky", {31'd0, ill_a}, 32'd1);
    chk("illegal no bus_err", {31'd0, berr_a}, 32'd0);
    do_reset();

    // Configuration B: illegal ops ignored, ADDIU disabled, no timeout.
    issue(O_BAD, 0, 0, 1'b1);   drain(O_BAD, 1'b1);
    chk("b illegal ignored", {31'd0, ill_b}, 32'd0);
    issue(O_ADDIU, 0, 0, 1'b1); drain(O_ADDIU, 1'b1);
    issue(O_RR, 20, 0, 1'b1);   drain(O_RR, 1'b1);
    issue(O_ADDI, 0, 0, 1'b1);  drain(O_ADDI, 1'b1);
    issue(O_LW, 0, 6, 1'b1);    drain(O_LW, 1'b1);
    chk("b flags clean", {30'd0, ill_b, berr_b}, 32'd0);
    chk("scoreboard empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
